div_unit: RTL and testbench



---
 rtl/div_unit.sv | 128 ++++++++++++
 tb/tb_div_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M div/divu/rem/remu.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow without iterating.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  kill_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  dz_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    rem_sel_q, neg_q_q, neg_r_q, dz_q, early_q;
    logic [DATA_WIDTH-1:0]   dvd_q, dvs_q, rem_q;

    logic                    accept, sgn_op, b_zero, special, fit;
    logic [DATA_WIDTH:0]     rem_sh, diff;
    logic [DATA_WIDTH-1:0]   q_fix, r_fix;

    function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v,
                                                       input logic neg);
        return neg ? (~v + ONE) : v;
    endfunction

    assign accept = start_i && !kill_i && (state_q == IDLE || state_q == DONE);
    assign sgn_op = ~op_i[0];
    assign b_zero = (b_i == '0);

`ifdef DIV_EARLY_OUT_EN
    logic ovf;
    assign ovf     = sgn_op && (a_i == SMIN) && (b_i == '1);
    assign special = b_zero || ovf;
`else
    assign special = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, keep the difference if it fits
    assign rem_sh = {rem_q, dvd_q[DATA_WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign fit    = ~diff[DATA_WIDTH];

    assign q_fix  = dz_q ? '1 : cond_neg(dvd_q, neg_q_q);
    assign r_fix  = cond_neg(rem_q, neg_r_q);

    assign busy_o = (state_q == CALC) || (state_q == FIX && !early_q);
    assign done_o = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept)                state_d = special ? FIX : CALC;
                else if (state_q == DONE)  state_d = IDLE;
            end
            CALC: begin
                if (kill_i)                      state_d = IDLE;
                else if (cnt_q == CNT_W'(1))     state_d = FIX;
            end
            FIX:     state_d = kill_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            dz_q      <= 1'b0;
            early_q   <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            res_o     <= '0;
            dz_o      <= 1'b0;
        end else begin
            if (accept) begin
                rem_sel_q <= op_i[1];
                cnt_q     <= CNT_W'(DATA_WIDTH);
                dz_q      <= b_zero;
                early_q   <= special;
                if (special) begin
                    // Preload the final magnitudes so FIX selects the special result unchanged
                    neg_q_q <= 1'b0;
                    neg_r_q <= 1'b0;
                    dvd_q   <= SMIN;
                    dvs_q   <= b_i;
                    rem_q   <= b_zero ? a_i : '0;
                end else begin
                    neg_q_q <= sgn_op && (a_i[DATA_WIDTH-1] ^ b_i[DATA_WIDTH-1]);
                    neg_r_q <= sgn_op && a_i[DATA_WIDTH-1];
                    dvd_q   <= cond_neg(a_i, sgn_op && a_i[DATA_WIDTH-1]);
                    dvs_q   <= cond_neg(b_i, sgn_op && b_i[DATA_WIDTH-1]);
                    rem_q   <= '0;
                end
            end else if (state_q == CALC) begin
                rem_q <= fit ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
                dvd_q <= {dvd_q[DATA_WIDTH-2:0], fit};
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (state_q == FIX && !kill_i) begin
                res_o <= rem_sel_q ? r_fix : q_fix;
                dz_o  <= dz_q;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors, kill, reset and back-to-back cases.
`timescale 1ns/1ps
module tb_div_unit;

    localparam int W = 32;
    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic         kill_i = 1'b0;
    logic [1:0]   op_i = '0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         busy_o, done_o, dz_o;
    logic [W-1:0] res_o;

    div_unit #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .kill_i(kill_i), .busy_o(busy_o), .done_o(done_o), .res_o(res_o), .dz_o(dz_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         dz;
        int           cyc;
    } exp_t;
    exp_t sb[$];

    logic [W-1:0] last_res = '0;
    logic         last_dz = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done_o), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res", res_o, e.res);
                chk("dz", 32'(dz_o), 32'(e.dz));
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic edz, input bit push);
        exp_t e;
        int   lat;
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        lat = 33;
`ifdef DIV_EARLY_OUT_EN
        if (b == '0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) lat = 1;
`endif
        @(posedge clk); #1;
        start_i = 1'b0;
        a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
        if (push) begin
            e.res = er; e.dz = edz; e.cyc = cyc + lat;
            sb.push_back(e);
            last_res = er; last_dz = edz;
        end
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (done_o) got = 1'b1;
        end
        if (!got) chk("done_timeout", 32'(got), 32'(1));
    endtask

    task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic edz);
        issue(op, a, b, er, edz, 1'b1);
        wait_done();
        @(negedge clk);
        chk("done_pulse", 32'(done_o), 32'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_done", 32'(done_o), 32'(0));
        chk("rst_res", res_o, 32'(0));
        chk("rst_dz", 32'(dz_o), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        run(DIVU, 32'd100,        32'd7,          32'd14,         1'b0);
        run(REMU, 32'd100,        32'd7,          32'd2,          1'b0);
        run(DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0);
        run(REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0);
        run(REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0);
        run(DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0);
        run(REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b0);
        run(DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0);
        run(DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1);
        run(REMU, 32'd5,          32'd0,          32'd5,          1'b1);
        run(DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1'b1);
        run(REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1);
        run(DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0);
        run(REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0);

        // start together with kill in IDLE is suppressed
        op_i = DIVU; a_i = 32'd9; b_i = 32'd3; start_i = 1'b1; kill_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; kill_i = 1'b0;
        chk("kill_idle_busy", 32'(busy_o), 32'(0));

        // kill mid-calculation: no done, result held, then a fresh op completes
        issue(DIVU, 32'd1000, 32'd10, 32'd100, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        chk("kill_busy", 32'(busy_o), 32'(0));
        chk("kill_res", res_o, last_res);
        chk("kill_dz", 32'(dz_o), 32'(last_dz));
        run(DIVU, 32'd1000, 32'd10, 32'd100, 1'b0);

        // back-to-back: second start accepted in the done cycle
        issue(DIVU, 32'd1000, 32'd7, 32'd142, 1'b0, 1'b1);
        wait_done();
        issue(REMU, 32'd1000, 32'd7, 32'd6, 1'b0, 1'b1);
        chk("b2b_busy", 32'(busy_o), 32'(1));
        wait_done();
        @(negedge clk);

        // reset mid-operation clears every output
        issue(DIV, 32'd77, 32'd3, 32'd25, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy_o), 32'(0));
        chk("mid_rst_done", 32'(done_o), 32'(0));
        chk("mid_rst_res", res_o, 32'(0));
        chk("mid_rst_dz", 32'(dz_o), 32'(0));
        run(DIV, 32'd77, 32'd3, 32'd25, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
